dest_track_pipeline: RTL

- Pipeline-side counterpart of the hazard detection unit.
- Consumes the active-low `pipeline_stall_n` request and carries each issued instruction's destination register through the EX, MEM and WB slots.
- Supplies `ex_op_dest`, `mem_op_dest` and `wb_op_dest` back to the hazard unit, freezes IF/ID and inserts bubbles into EX during stalls.
- Also keeps stall and retire statistics and flags stall-protocol violations.

---
 rtl/mips16_pipe_pkg.sv | 30 +++
 rtl/pipe_slot_reg.sv | 20 ++
 rtl/dest_track_pipeline.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips16_pipe_pkg.sv
// Shared types and constants for the destination-tracking pipeline.
package mips16_pipe_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int INSTR_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // One pipeline slot: what the hazard unit needs plus the instruction word.
  typedef struct packed {
    logic                  valid;
    logic                  write_en;
    logic [REG_ADDR_W-1:0] dest;
    logic [INSTR_W-1:0]    instr;
  } pipe_slot_t;

  localparam pipe_slot_t BUBBLE_SLOT = '{
    valid:    1'b0,
    write_en: 1'b0,
    dest:     '0,
    instr:    NOP_INSTR
  };

  // A slot only produces a hazard when it really writes; r0 is never a hazard
  // because its dest value is already zero.
  function automatic logic [REG_ADDR_W-1:0] eff_dest(input pipe_slot_t s);
    return (s.valid && s.write_en) ? s.dest : '0;
  endfunction

endpackage

// File: rtl/pipe_slot_reg.sv
// Single pipeline slot register with synchronous reset and bubble select.
module pipe_slot_reg
  import mips16_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_bubble,
  input  pipe_slot_t d,
  output pipe_slot_t q
);

  // Load the next slot contents, a bubble, or flush on reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every slot samples its neighbour's
    // pre-edge value; blocking here would let an instruction skip stages.
    if (rst || load_bubble) q <= BUBBLE_SLOT;
    else                    q <= d;
  end

endmodule

// File: rtl/dest_track_pipeline.sv
// Carries destination registers through EX/MEM/WB for the hazard unit,
// inserts bubbles on stall, and keeps stall/retire statistics.
module dest_track_pipeline
  import mips16_pipe_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [INSTR_W-1:0]    id_instr,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_write_en,
  input  logic                  pipeline_stall_n,
  output logic [REG_ADDR_W-1:0] ex_op_dest,
  output logic [REG_ADDR_W-1:0] mem_op_dest,
  output logic [REG_ADDR_W-1:0] wb_op_dest,
  output logic [INSTR_W-1:0]    ex_instr,
  output logic                  ex_valid,
  output logic                  if_id_hold,
  output logic                  bubble_inserted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic                  stall_err
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  logic       stall;
  pipe_slot_t id_slot;
  pipe_slot_t ex_slot, mem_slot, wb_slot;
  logic [RUN_W-1:0] run_cnt;

  assign stall = !pipeline_stall_n;

  // Pack the ID-stage fields into a slot.
  always_comb begin
    id_slot          = BUBBLE_SLOT;
    id_slot.valid    = id_valid;
    id_slot.write_en = id_write_en;
    id_slot.dest     = id_dest;
    id_slot.instr    = id_instr;
  end

  // The slots always advance; a stall only replaces what enters EX.
  pipe_slot_reg u_ex (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (stall || !id_valid),
    .d           (id_slot),
    .q           (ex_slot)
  );

  pipe_slot_reg u_mem (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (1'b0),
    .d           (ex_slot),
    .q           (mem_slot)
  );

  pipe_slot_reg u_wb (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (1'b0),
    .d           (mem_slot),
    .q           (wb_slot)
  );

  // Effective destinations straight from slot registers, so the hazard unit
  // sees no combinational path back from its own stall output.
  assign ex_op_dest  = eff_dest(ex_slot);
  assign mem_op_dest = eff_dest(mem_slot);
  assign wb_op_dest  = eff_dest(wb_slot);
  assign ex_instr    = ex_slot.instr;
  assign ex_valid    = ex_slot.valid;
  assign if_id_hold  = stall;

  // Bubble flag, statistics counters and the stall-run watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_inserted <= 1'b0;
      stall_cycles    <= '0;
      retired_cnt     <= '0;
      run_cnt         <= '0;
      stall_err       <= 1'b0;
    end else begin
      // Only a stall-driven bubble is reported; id_valid=0 bubbles are normal.
      bubble_inserted <= stall;

      if (wb_slot.valid && (retired_cnt != '1))
        retired_cnt <= retired_cnt + 1'b1;

      if (stall) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
        // A run longer than the pipeline depth means the producer already
        // left WB, so the hazard unit is stuck.
        if (run_cnt == RUN_W'(MAX_STALL)) stall_err <= 1'b1;
        else                              run_cnt   <= run_cnt + 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule
